// File: rtl/sram_ctl_pkg.sv
// Shared definitions for the SRAM controller ingress path: default widths,
// port count and the packet framing state encoding.
package sram_ctl_pkg;

    localparam int DATA_WIDTH = 256;
    localparam int NUM_PORTS  = 16;

    // Framing state of one ingress port.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } frame_state_e;

    // A word is legal only if it opens a packet when idle, or continues one
    // when inside a packet.
    function automatic logic frame_ok(input frame_state_e st, input logic sop);
        return (st == ST_IDLE) ? sop : !sop;
    endfunction

endpackage

// File: rtl/port_ingress_buffer_sync_fifo.sv
// First-word-fall-through FIFO. Storage is a plain array with a registered
// read so it maps onto block RAM. The read address is the next-cycle head
// pointer, so the head word is always waiting in the read register. A word
// written into the slot that is about to become the head is forwarded
// through a bypass register, because a registered read of that slot would
// still return the old contents.
module sync_fifo #(
    parameter int WIDTH = 258,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             byp_q, byp_d;
    logic [WIDTH-1:0] byp_data_q, byp_data_d;
    logic [WIDTH-1:0] ram_rd_q;
    logic             push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Pointer, count and bypass next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        push_ok    = push && !full;
        pop_ok     = pop && !empty;
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
        byp_d      = push_ok && (wr_ptr_q == rd_ptr_d);
        byp_data_d = wdata;
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            byp_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            byp_q    <= byp_d;
        end
    end

    // Storage with registered read of the upcoming head slot.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
        ram_rd_q <= mem[rd_ptr_d];
    end

    // Bypass data register; only meaningful when byp_q is set.
    always_ff @(posedge clk) begin
        byp_data_q <= byp_data_d;
    end

    assign rdata = byp_q ? byp_data_q : ram_rd_q;

endmodule

// File: rtl/port_ingress_buffer.sv
// Per-port ingress buffer: checks packet framing on the incoming word
// stream, stores legal words in a FWFT FIFO and tells the write arbiter
// when at least one complete packet is waiting. One instance is built per
// ingress port and its outputs feed the write arbiter bit-for-bit.
module port_ingress_buffer #(
    parameter int DATA_WIDTH = sram_ctl_pkg::DATA_WIDTH,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_full,
    output logic                  err,
    output logic                  ready,
    output logic                  vld,
    output logic                  sop,
    output logic                  eop,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  next_data
);

    import sram_ctl_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    frame_state_e          state_q, state_d;
    logic [CW-1:0]         pkt_cnt_q, pkt_cnt_d;
    logic                  fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [DATA_WIDTH+1:0] fifo_wdata, fifo_rdata;
    logic                  word_err;
    logic                  head_vld;

    assign fifo_wdata = {in_sop, in_eop, in_data};
    assign head_vld   = !rst && !fifo_empty;
    assign fifo_pop   = head_vld && next_data;

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Framing state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next framing state: every accepted word ends in IDLE if it carries eop,
    // otherwise inside a packet; rejected words leave the state alone.
    always_comb begin
        state_d = state_q;
        if (fifo_push) begin
            state_d = in_eop ? ST_IDLE : ST_IN_PKT;
        end
    end

    // Accept/reject decision: illegal framing raises err even when full.
    always_comb begin
        fifo_push = 1'b0;
        word_err  = 1'b0;
        if (!rst && in_vld) begin
            if (!frame_ok(state_q, in_sop)) begin
                word_err = 1'b1;
            end else if (!fifo_full) begin
                fifo_push = 1'b1;
            end
        end
    end

    // Complete-packet count: eop words entering minus eop words leaving.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if ((fifo_push && in_eop) && !(fifo_pop && fifo_rdata[DATA_WIDTH])) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end else if (!(fifo_push && in_eop) && (fifo_pop && fifo_rdata[DATA_WIDTH])) begin
            pkt_cnt_d = pkt_cnt_q - 1'b1;
        end
    end

    // Packet counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign in_full  = !rst && fifo_full;
    assign err      = word_err;
    assign ready    = !rst && (pkt_cnt_q != '0);
    assign vld      = head_vld;
    assign sop      = head_vld && fifo_rdata[DATA_WIDTH+1];
    assign eop      = head_vld && fifo_rdata[DATA_WIDTH];
    assign data_out = head_vld ? fifo_rdata[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_port_ingress_buffer.sv
// Bench for port_ingress_buffer: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a queue-based packet model.
module tb_port_ingress_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_vld = 1'b0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          next_data = 1'b0;
    logic          in_full, err, ready, vld, sop, eop;
    logic [DW-1:0] data_out;

    always #5 clk = ~clk;

    port_ingress_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_data   (in_data),
        .in_full   (in_full),
        .err       (err),
        .ready     (ready),
        .vld       (vld),
        .sop       (sop),
        .eop       (eop),
        .data_out  (data_out),
        .next_data (next_data)
    );

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } entry_t;

    // Model: buffered words in arrival order, plus whether the port is
    // currently inside a packet.
    entry_t mq[$];
    bit     m_in_pkt = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eop_count();
        int n = 0;
        foreach (mq[i]) if (mq[i].eop) n++;
        return n;
    endfunction

    // Apply the rules to the inputs present at this clock edge.
    task automatic model_update();
        bit     can_push;
        entry_t e;
        if (rst) begin
            mq.delete();
            m_in_pkt = 1'b0;
        end else begin
            can_push = in_vld && (mq.size() < DEPTH) && (m_in_pkt ? !in_sop : in_sop);
            if (next_data && mq.size() > 0) void'(mq.pop_front());
            if (can_push) begin
                e.sop  = in_sop;
                e.eop  = in_eop;
                e.data = in_data;
                mq.push_back(e);
                m_in_pkt = !in_eop;
            end
        end
    endtask

    // One clock: the model consumes the current inputs at the edge, then
    // the next cycle's inputs are applied.
    task automatic step(input logic r, input logic v, input logic s, input logic e,
                        input logic [DW-1:0] d, input logic nd);
        @(posedge clk);
        model_update();
        #1;
        rst = r; in_vld = v; in_sop = s; in_eop = e; in_data = d; next_data = nd;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    initial begin
        logic exp_vld;
        forever begin
            @(negedge clk);
            exp_vld = !rst && (mq.size() > 0);
            chk("vld", vld, exp_vld);
            chk("in_full", in_full, !rst && (mq.size() == DEPTH));
            chk("ready", ready, !rst && (eop_count() > 0));
            chk("err", err, !rst && in_vld && (m_in_pkt ? in_sop : !in_sop));
            if (exp_vld) begin
                chk("sop", sop, mq[0].sop);
                chk("eop", eop, mq[0].eop);
                chk("data_out", data_out, mq[0].data);
            end
            if (rst) begin
                chk("rst_sop", sop, 0);
                chk("rst_eop", eop, 0);
                chk("rst_data", data_out, 0);
            end
        end
    end

    initial begin
        int drained;
        int pv, pn;

        // Reset state.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        at_neg();
        chk("reset_vld", vld, 0);
        chk("reset_ready", ready, 0);
        chk("reset_in_full", in_full, 0);
        chk("reset_err", err, 0);

        // One-word packet 0xA5, popped right after it appears.
        step(0, 1, 1, 1, 'hA5, 0);
        step(0, 0, 0, 0, 0, 1);
        at_neg();
        chk("one_word_vld", vld, 1);
        chk("one_word_sop", sop, 1);
        chk("one_word_eop", eop, 1);
        chk("one_word_ready", ready, 1);
        chk("one_word_data", data_out, 'hA5);
        step(0, 0, 0, 0, 0, 0);
        at_neg();
        chk("one_word_pop_vld", vld, 0);
        chk("one_word_pop_ready", ready, 0);

        // Three-word packet 1,2,3: ready only after the eop word.
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 0, 0, 2, 0);
        at_neg();
        chk("pkt3_ready_w1", ready, 0);
        step(0, 1, 0, 1, 3, 0);
        at_neg();
        chk("pkt3_ready_w2", ready, 0);
        step(0, 0, 0, 0, 0, 0);
        at_neg();
        chk("pkt3_ready_w3", ready, 1);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 0, 0, 1);
            at_neg();
            chk("pkt3_data", data_out, i);
            chk("pkt3_sop", sop, (i == 1));
            chk("pkt3_eop", eop, (i == 3));
        end
        step(0, 0, 0, 0, 0, 0);
        at_neg();
        chk("pkt3_empty", vld, 0);

        // Framing errors: no-sop word in IDLE, sop inside a packet.
        step(0, 1, 0, 0, 'h77, 0);
        at_neg();
        chk("err_nosop", err, 1);
        step(0, 1, 1, 0, 'h10, 0);
        at_neg();
        chk("err_clear1", err, 0);
        step(0, 1, 1, 0, 'h11, 0);
        at_neg();
        chk("err_sop_in_pkt", err, 1);
        step(0, 1, 0, 1, 'h12, 0);
        at_neg();
        chk("err_clear2", err, 0);
        step(0, 0, 0, 0, 0, 0);
        at_neg();
        chk("err_model_size", mq.size(), 2);
        chk("err_head", data_out, 'h10);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // Push+pop at count 5, eop in and eop out together.
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 'h20 + i, 0);
        step(0, 1, 1, 1, 'h30, 1);
        step(0, 0, 0, 0, 0, 0);
        at_neg();
        chk("pp_model_size", mq.size(), 5);
        chk("pp_model_pkts", eop_count(), 5);
        chk("pp_ready", ready, 1);
        chk("pp_head", data_out, 'h21);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Fill to DEPTH, then a push with a simultaneous pop is refused.
        step(0, 1, 1, 0, 0, 0);
        for (int i = 1; i < DEPTH; i++) step(0, 1, 0, 0, i, 0);
        step(0, 1, 0, 0, 'hFF, 1);
        at_neg();
        chk("full_flag", in_full, 1);
        step(0, 0, 0, 0, 0, 1);
        at_neg();
        chk("full_after_pop", in_full, 0);
        chk("full_model_size", mq.size(), DEPTH - 1);
        drained = 0;
        for (int k = 0; k < DEPTH + 6; k++) begin
            if (vld) drained++;
            step(0, 0, 0, 0, 0, 1);
            at_neg();
        end
        chk("full_drained_words", drained, DEPTH - 1);

        // Reset with two packets and a partial packet buffered.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 0, 1, 2, 0);
        step(0, 1, 1, 1, 3, 0);
        step(0, 1, 1, 0, 4, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 'h55, 0);
        at_neg();
        chk("midrst_vld", vld, 0);
        chk("midrst_ready", ready, 0);
        chk("midrst_in_full", in_full, 0);
        chk("midrst_err", err, 1);
        step(0, 0, 0, 0, 0, 0);

        // Randomized traffic in fill / drain / balanced phases.
        for (int c = 0; c < 4000; c++) begin
            case ((c / 400) % 3)
                0:       begin pv = 90; pn = 15; end
                1:       begin pv = 40; pn = 90; end
                default: begin pv = 70; pn = 60; end
            endcase
            step(($urandom % 900) == 0,
                 ($urandom % 100) < pv,
                 m_in_pkt ? (($urandom % 10) == 0) : (($urandom % 10) != 0),
                 ($urandom % 4) == 0,
                 $urandom,
                 ($urandom % 100) < pn);
        end
        step(0, 0, 0, 0, 0, 0);
        at_neg();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/port_ingress_buffer.md
PORT_INGRESS_BUFFER -- requirements
Module: port_ingress_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256: width of one packet word.
REQ-002 SHALL have parameter DEPTH, default 64: buffer capacity in words, power of two, minimum 4.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_vld, input, 1: word on in_data/in_sop/in_eop offered by the ingress port.
REQ-006 SHALL have port in_sop, input, 1: offered word is the first word of a packet.
REQ-007 SHALL have port in_eop, input, 1: offered word is the last word of a packet.
REQ-008 SHALL have port in_data, input, DATA_WIDTH: offered word.
REQ-009 SHALL have port in_full, output, 1: buffer full; offered word is not accepted.
REQ-010 SHALL have port err, output, 1: one-cycle pulse on a framing violation.
REQ-011 SHALL have port ready, output, 1: at least one complete packet is buffered (arbiter request).
REQ-012 SHALL have port vld, output, 1: head word present on data_out.
REQ-013 SHALL have ports sop and eop, outputs, 1 each: framing flags of the head word.
REQ-014 SHALL have port data_out, output, DATA_WIDTH: head word.
REQ-015 SHALL have port next_data, input, 1: arbiter grant; pops the head word.

Function
REQ-016 SHALL accept a word (push) when in_vld=1, in_full=0 and the framing FSM allows it; each stored entry holds {sop, eop, data}.
REQ-017 SHALL run a framing FSM with states IDLE and IN_PKT; IDLE->IN_PKT on an accepted sop without eop; IN_PKT->IDLE on an accepted eop; sop+eop together in IDLE is a one-word packet and stays in IDLE.
REQ-018 SHALL drop the word and pulse err when in_vld=1 without in_sop in IDLE, or with in_sop in IN_PKT; the FSM state is unchanged.
REQ-019 SHALL assert in_full combinationally when word count equals DEPTH; a pop in the same cycle SHALL NOT permit a push.
REQ-020 SHALL be first-word fall-through: a word pushed into an empty buffer appears with vld=1 in the next cycle.
REQ-021 SHALL pop the head when vld=1 and next_data=1; the next word, or vld=0 if empty, appears in the following cycle; next_data with vld=0 SHALL be ignored.
REQ-022 SHALL allow simultaneous push and pop when not full; the word count is unchanged.
REQ-023 SHALL keep a packet counter, width log2(DEPTH)+1: increment on an accepted eop push; decrement on an eop pop; unchanged when both occur in one cycle; ready = (counter != 0).
REQ-024 SHALL keep sop, eop and data_out stable while vld=1 and no pop occurs; their values are don't-care while vld=0.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; the word count, width log2(DEPTH)+1, distinguishes full from empty.

Reset
REQ-026 SHALL, while rst=1, set FSM to IDLE and set pointers, word count and packet counter to 0.
REQ-027 SHALL, while rst=1, drive vld=0, ready=0, err=0, in_full=0, sop=0, eop=0 and data_out=0.
REQ-028 SHALL discard all buffered and partial packets on reset mid-operation; in_vld and next_data are ignored during reset.

Structure
REQ-029 SHALL take DATA_WIDTH and NUM_PORTS=16 defaults from a shared package sram_ctl_pkg, which also holds the FSM state encoding.
REQ-030 SHALL place storage and pointers in one sub-module sync_fifo (FWFT, width DATA_WIDTH+2); framing FSM, packet counter and err stay in the top level.
REQ-031 SHALL be instantiated once per port, num_of_ports instances, feeding the write arbiter bit-for-bit.

Verification
REQ-032 SHALL cover a one-word packet (sop=eop=1, data=0xA5) pushed at cycle 0 -> vld=1, sop=1, eop=1, ready=1, data_out=0xA5 at cycle 1; next_data at cycle 1 -> vld=0 and ready=0 at cycle 2.
REQ-033 SHALL cover a 3-word packet with words 1, 2, 3 -> ready=0 until the eop push; then three pops return 1, 2, 3 with sop only on 1 and eop only on 3.
REQ-034 SHALL cover full: push 64 words without pops -> in_full=1; a 65th push with simultaneous next_data -> word not stored, count stays 63 after the pop.
REQ-035 SHALL cover framing errors: a word without sop in IDLE, and an sop inside a packet -> err pulses one cycle each; neither word is stored.
REQ-036 SHALL cover simultaneous push and pop at count 5 -> count stays 5; eop push and eop pop in one cycle -> packet count unchanged.
REQ-037 SHALL cover rst asserted with 2 packets buffered and one partial packet -> next cycle vld=0, ready=0, in_full=0; a following non-sop word -> err=1.
